iterative_alu: RTL and testbench
================================

# iterative_alu

Parametrised, handshaked execution unit for the pipelined datapath. It replaces the single-cycle combinational ALU in the EX stage. It keeps the same 4-bit ALUControl encoding, generalises the datapath to DATA_W bits, and adds multi-cycle shift-add multiply and restoring divide. Stalls reach the ID/EX latch through `in_ready`, and a one-entry output register holds each result until it is consumed.

## Interface
- DATA_W, 8, operand/result width; legal range 4..32
- CNT_W, $clog2(DATA_W+1), iteration counter width (derived; do not override)
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_valid  in  1  operation request valid
- in_ready  out  1  unit accepts request this cycle
- alu_ctrl  in  4  opcode, ALUControl encoding
- src_a  in  DATA_W  operand A
- src_b  in  DATA_W  operand B
- out_valid  out  1  result registered and valid
- out_ready  in  1  consumer takes result this cycle
- result  out  DATA_W  primary result; MUL low half, DIV quotient
- result_hi  out  DATA_W  MUL high half, DIV remainder; 0 for all other ops
- zero  out  1  result == 0 (registered with result)
- div_by_zero  out  1  DIV with src_b == 0
- busy  out  1  iterative MUL/DIV in progress

## Operation
- Opcodes:
  - 1000 ADD; 1001 SUB (two's complement); 1010 MUL (unsigned); 1011 DIV (unsigned).
  - 1100 AND; 1101 OR; 1110 NOT (~src_a); 1111 XOR.
  - 0110 SRA (src_a arithmetic right shift by 1); 0111 SHL (src_a << 1).
  - 0101 EQ (result 1 if src_a == src_b, else 0).
  - Any other code: result 0, zero 1.
- All arithmetic is modulo 2^DATA_W. MUL gives a full 2*DATA_W product as {result_hi, result}.
- Handshake:
  - in_ready = !reset && state == IDLE && (!out_valid || out_ready).
  - Accept on in_valid && in_ready. Output transfer on out_valid && out_ready.
- FSM states:
  - IDLE: accepting. A single-cycle op, or DIV with src_b == 0, writes the output register at the accept edge. MUL or DIV with src_b != 0 latches operands, loads the counter with DATA_W and moves to ITER.
  - ITER: busy = 1, one shift-add (MUL) or restore-subtract (DIV) step per cycle, counter decrements. When the counter reaches 1, that edge writes the output register, sets out_valid and returns to IDLE.
- Output register:
  - out_valid clears on transfer unless a new result loads at the same edge.
  - If out_valid && !out_ready, result, result_hi, zero and div_by_zero hold stable and in_ready = 0.
- Divide by zero: result 0, result_hi = src_a, div_by_zero 1, zero 1. Takes the single-cycle path with no iteration.
- alu_ctrl and operands are ignored unless accepted. Inputs may change freely during ITER.

## Timing
- Reset values: out_valid 0, result 0, result_hi 0, zero 0, div_by_zero 0, busy 0, state IDLE, counter 0. in_ready is 0 while reset is high.
- Reset mid-ITER aborts the operation; no result is ever presented. in_ready = 1 in the first cycle after reset deasserts.
- Single-cycle ops: accept at edge k, out_valid is visible in cycle k+1.
- Iterative MUL/DIV: accept at edge k, out_valid is visible in cycle k+DATA_W. in_ready = 0 for cycles k+1..k+DATA_W-1.
- Simultaneous output transfer and new accept at the same edge: the old result leaves and the new one loads. For a single-cycle op, out_valid stays high. For an iterative op, out_valid drops until that op completes.
- Throughput: one single-cycle op per clock with out_ready held high.

## Configuration
- ITERATIVE_ALU_FAST_MUL_EN:
  - Defined: MUL computes the full product in one cycle with a combinational multiplier and takes the single-cycle path (latency 1). busy never asserts for MUL.
  - Undefined (default): MUL is iterative with DATA_W-cycle latency as above. DIV is always iterative.

## Test plan
- DATA_W=8, MUL 200×3 accepted at edge k: out_valid in cycle k+8, result 0x58, result_hi 0x02, busy high cycles k+1..k+7. With ITERATIVE_ALU_FAST_MUL_EN defined: same values in cycle k+1.
- DIV 100/7: result 14, result_hi 2, latency 8. DIV 9/0: result 0, result_hi 9, div_by_zero 1, zero 1, latency 1.
- Back-to-back single-cycle ops with out_ready held high (ADD 5+6, SUB 5−6, SRA 0x90, EQ 6,6): results 11, 0xFF, 0xC8, 1 on consecutive cycles; zero 0 throughout.
- Backpressure: ADD result pending with out_ready low for 3 cycles. result is held at 11, in_ready 0, and a new in_valid is not accepted. When out_ready rises, transfer and new accept happen at the same edge.
- Reset pulsed during cycle k+3 of DIV 100/7: out_valid never asserts for that operation. All outputs are 0 the cycle after the reset edge, and in_ready is 1 once reset is low.
- Undefined opcode 0000 with src_a=5, src_b=6: result 0, zero 1, result_hi 0, latency 1.

Source files
------------

// File: rtl/iterative_alu.sv
// Handshaked EX-stage ALU: single-cycle ops plus iterative shift-add MUL and restoring DIV.
// Define ITERATIVE_ALU_FAST_MUL_EN to compute MUL combinationally on the single-cycle path.
module iterative_alu #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic              zero,
    output logic              div_by_zero,
    output logic              busy
);

    localparam logic [3:0] OP_EQ  = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;
    localparam logic [3:0] OP_AND = 4'b1100;
    localparam logic [3:0] OP_OR  = 4'b1101;
    localparam logic [3:0] OP_NOT = 4'b1110;
    localparam logic [3:0] OP_XOR = 4'b1111;

    typedef enum logic {IDLE, ITER} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  work_hi_q, work_lo_q, work_b_q;
    logic               work_div_q;

    logic               accept;
    logic               is_iter_op;
    logic               start_iter;
    logic               last_step;

    logic [DATA_W-1:0]  step_hi_in, step_lo_in, step_b_in;
    logic               step_div;
    logic [DATA_W:0]    mul_sum;
    logic [DATA_W:0]    div_shifted, div_trial;
    logic [DATA_W-1:0]  step_hi_nx, step_lo_nx;

    logic [DATA_W-1:0]  sc_result, sc_hi;
    logic               sc_dbz;

`ifdef ITERATIVE_ALU_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_prod  = (2*DATA_W)'(src_a) * (2*DATA_W)'(src_b);
    assign is_iter_op = (alu_ctrl == OP_DIV) && (src_b != '0);
`else
    assign is_iter_op = (alu_ctrl == OP_MUL) || ((alu_ctrl == OP_DIV) && (src_b != '0));
`endif

    assign accept     = in_valid && in_ready;
    assign start_iter = accept && is_iter_op;
    // The first step runs at the accept edge, so the final step is taken while the counter reads 2.
    assign last_step  = (state_q == ITER) && (cnt_q == CNT_W'(2));

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_iter) state_d = ITER;
            ITER:    if (last_step)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state_q == ITER);
        in_ready = !reset && (state_q == IDLE) && (!out_valid || out_ready);
    end

    // ---------------- Iteration step datapath ----------------
    always_comb begin
        if (state_q == IDLE) begin
            step_hi_in = '0;
            step_lo_in = src_a;
            step_b_in  = src_b;
            step_div   = (alu_ctrl == OP_DIV);
        end else begin
            step_hi_in = work_hi_q;
            step_lo_in = work_lo_q;
            step_b_in  = work_b_q;
            step_div   = work_div_q;
        end
    end

    // Shift-add: add multiplicand when the multiplier LSB is set, then shift {carry,hi,lo} right.
    assign mul_sum     = {1'b0, step_hi_in} + (step_lo_in[0] ? {1'b0, step_b_in} : '0);
    // Restoring divide: the partial remainder stays below the divisor, so DATA_W+1 bits suffice.
    assign div_shifted = {step_hi_in, step_lo_in[DATA_W-1]};
    assign div_trial   = div_shifted - {1'b0, step_b_in};

    always_comb begin
        step_hi_nx = mul_sum[DATA_W:1];
        step_lo_nx = {mul_sum[0], step_lo_in[DATA_W-1:1]};
        if (step_div) begin
            if (!div_trial[DATA_W]) begin
                step_hi_nx = div_trial[DATA_W-1:0];
                step_lo_nx = {step_lo_in[DATA_W-2:0], 1'b1};
            end else begin
                step_hi_nx = div_shifted[DATA_W-1:0];
                step_lo_nx = {step_lo_in[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset)                 cnt_q <= '0;
        else if (start_iter)       cnt_q <= CNT_W'(DATA_W);
        else if (state_q == ITER)  cnt_q <= cnt_q - CNT_W'(1);
    end

    // NOTE: working registers carry no reset; they are always loaded at the accept edge before use.
    always_ff @(posedge CLK) begin
        if (start_iter) begin
            work_hi_q  <= step_hi_nx;
            work_lo_q  <= step_lo_nx;
            work_b_q   <= src_b;
            work_div_q <= (alu_ctrl == OP_DIV);
        end else if (state_q == ITER) begin
            work_hi_q  <= step_hi_nx;
            work_lo_q  <= step_lo_nx;
        end
    end

    // ---------------- Single-cycle operations ----------------
    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_dbz    = 1'b0;
        case (alu_ctrl)
            OP_ADD: sc_result = src_a + src_b;
            OP_SUB: sc_result = src_a - src_b;
`ifdef ITERATIVE_ALU_FAST_MUL_EN
            OP_MUL: {sc_hi, sc_result} = fast_prod;
`endif
            // Only reaches the output register when src_b is zero.
            OP_DIV: begin
                sc_hi  = src_a;
                sc_dbz = 1'b1;
            end
            OP_AND: sc_result = src_a & src_b;
            OP_OR:  sc_result = src_a | src_b;
            OP_NOT: sc_result = ~src_a;
            OP_XOR: sc_result = src_a ^ src_b;
            OP_SRA: sc_result = {src_a[DATA_W-1], src_a[DATA_W-1:1]};
            OP_SHL: sc_result = {src_a[DATA_W-2:0], 1'b0};
            OP_EQ:  sc_result = DATA_W'(src_a == src_b);
            default: ;
        endcase
    end

    // ---------------- Output register ----------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            out_valid   <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept && !is_iter_op) begin
            out_valid   <= 1'b1;
            result      <= sc_result;
            result_hi   <= sc_hi;
            zero        <= (sc_result == '0);
            div_by_zero <= sc_dbz;
        end else if (last_step) begin
            out_valid   <= 1'b1;
            result      <= step_lo_nx;
            result_hi   <= step_hi_nx;
            zero        <= (step_lo_nx == '0);
            div_by_zero <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: directed cases plus randomized ops vs a behavioural model.
`timescale 1ns/1ps
module tb_iterative_alu;

    localparam int DATA_W = 8;
`ifdef ITERATIVE_ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = DATA_W;
`endif

    typedef struct {
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] hi;
        logic              z;
        logic              dbz;
        int                lat;
        int                vis;
    } exp_t;

    logic              CLK = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] src_a, src_b;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] result, result_hi;
    logic              zero, div_by_zero, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   head_seen = -1;
    int   rdy_mode = 1;
    exp_t sb[$];

    iterative_alu #(.DATA_W(DATA_W)) dut (
        .CLK(CLK), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .zero(zero), .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] h,
                                input logic z, input logic d, input int lat);
        exp_t e;
        e.res = r; e.hi = h; e.z = z; e.dbz = d; e.lat = lat; e.vis = 0;
        return e;
    endfunction

    // Reference model straight from the opcode table.
    function automatic exp_t model(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
        exp_t e;
        logic [2*DATA_W-1:0] p;
        e.res = '0; e.hi = '0; e.dbz = 1'b0; e.lat = 1; e.vis = 0;
        case (op)
            4'h8: e.res = a + b;
            4'h9: e.res = a - b;
            4'hA: begin
                p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
                e.res = p[DATA_W-1:0];
                e.hi  = p[2*DATA_W-1:DATA_W];
                e.lat = MUL_LAT;
            end
            4'hB: begin
                if (b == '0) begin
                    e.hi = a; e.dbz = 1'b1;
                end else begin
                    e.res = a / b; e.hi = a % b; e.lat = DATA_W;
                end
            end
            4'hC: e.res = a & b;
            4'hD: e.res = a | b;
            4'hE: e.res = ~a;
            4'hF: e.res = a ^ b;
            4'h6: e.res = (a / 2) | (a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : '0);
            4'h7: e.res = a + a;
            4'h5: e.res = (a == b) ? DATA_W'(1) : '0;
            default: ;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [3:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input exp_t e, input bit push);
        int waited = 0;
        in_valid = 1'b1; alu_ctrl = op; src_a = a; src_b = b;
        while (1) begin
            @(negedge CLK);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        if (push) begin
            e.vis = cyc + e.lat;
            sb.push_back(e);
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    // Waits for the scoreboard to empty; ends on a negedge.
    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge CLK);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(negedge CLK);
    endtask

    // Monitor: note when each result first appears, compare it on transfer.
    always @(negedge CLK) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                if (head_seen < 0) head_seen = cyc;
                if (out_ready) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result",      64'(result),      64'(e.res));
                    check("result_hi",   64'(result_hi),   64'(e.hi));
                    check("zero",        64'(zero),        64'(e.z));
                    check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    check("latency",     64'(head_seen),   64'(e.vis));
                    head_seen = -1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]        op;
        logic [DATA_W-1:0] a, b;

        reset = 1'b1; in_valid = 1'b0; alu_ctrl = '0; src_a = '0; src_b = '0;
        rdy_mode = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_result",      64'(result),      64'd0);
        check("rst_result_hi",   64'(result_hi),   64'd0);
        check("rst_zero",        64'(zero),        64'd0);
        check("rst_div_by_zero", 64'(div_by_zero), 64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        check("rst_in_ready",    64'(in_ready),    64'd0);
        @(posedge CLK); #1;
        reset = 1'b0;
        @(negedge CLK);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge CLK); #1;

        // MUL 200x3 with busy profile.
        issue(4'hA, DATA_W'(200), DATA_W'(3), mk(8'h58, 8'h02, 1'b0, 1'b0, MUL_LAT), 1'b1);
`ifdef ITERATIVE_ALU_FAST_MUL_EN
        @(negedge CLK);
        check("mul_busy_fast", 64'(busy), 64'd0);
`else
        for (int i = 1; i < DATA_W; i++) begin
            @(negedge CLK);
            check("mul_busy",     64'(busy),     64'd1);
            check("mul_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge CLK);
        check("mul_busy_done", 64'(busy), 64'd0);
`endif
        @(posedge CLK); #1;

        issue(4'hB, DATA_W'(100), DATA_W'(7), mk(8'd14, 8'd2, 1'b0, 1'b0, DATA_W), 1'b1);
        issue(4'hB, DATA_W'(9),   DATA_W'(0), mk(8'd0,  8'd9, 1'b1, 1'b1, 1),      1'b1);
        issue(4'h0, DATA_W'(5),   DATA_W'(6), mk(8'd0,  8'd0, 1'b1, 1'b0, 1),      1'b1);

        // Back-to-back single-cycle ops.
        issue(4'h8, DATA_W'(5),    DATA_W'(6), mk(8'd11,  8'd0, 1'b0, 1'b0, 1), 1'b1);
        issue(4'h9, DATA_W'(5),    DATA_W'(6), mk(8'hFF,  8'd0, 1'b0, 1'b0, 1), 1'b1);
        issue(4'h6, DATA_W'(8'h90), DATA_W'(0), mk(8'hC8, 8'd0, 1'b0, 1'b0, 1), 1'b1);
        issue(4'h5, DATA_W'(6),    DATA_W'(6), mk(8'd1,   8'd0, 1'b0, 1'b0, 1), 1'b1);

        // Backpressure: ADD held for 3 cycles, then transfer and new accept share an edge.
        drain(500);
        rdy_mode = 0;
        @(posedge CLK); #1;
        issue(4'h8, DATA_W'(5), DATA_W'(6), mk(8'd11, 8'd0, 1'b0, 1'b0, 1), 1'b1);
        in_valid = 1'b1; alu_ctrl = 4'hD; src_a = DATA_W'(8'h0F); src_b = DATA_W'(8'h30);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_result",    64'(result),    64'd11);
            if (i < 2) begin
                @(posedge CLK); #1;
            end
        end
        rdy_mode = 1;
        @(posedge CLK); #1;
        issue(4'hD, DATA_W'(8'h0F), DATA_W'(8'h30), mk(8'h3F, 8'd0, 1'b0, 1'b0, 1), 1'b1);

        // Reset during DIV 100/7: its result must never appear.
        drain(500);
        @(posedge CLK); #1;
        issue(4'hB, DATA_W'(100), DATA_W'(7), model(4'hB, DATA_W'(100), DATA_W'(7)), 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 1'b1;
        @(negedge CLK);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(posedge CLK); #1;
        reset = 1'b0;
        @(negedge CLK);
        check("abort_out_valid",   64'(out_valid),   64'd0);
        check("abort_result",      64'(result),      64'd0);
        check("abort_result_hi",   64'(result_hi),   64'd0);
        check("abort_zero",        64'(zero),        64'd0);
        check("abort_div_by_zero", 64'(div_by_zero), 64'd0);
        check("abort_busy",        64'(busy),        64'd0);
        check("abort_in_ready",    64'(in_ready),    64'd1);
        repeat (DATA_W + 4) @(posedge CLK);
        #1;

        // Randomized traffic with random backpressure.
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
            op = 4'($urandom_range(0, 15));
            a  = DATA_W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
            issue(op, a, b, model(op, a, b), 1'b1);
        end
        drain(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
